frame_stream_tx: RTL and testbench

FRAME_STREAM_TX -- requirements
Module: frame_stream_tx

---
 rtl/frame_stream_tx.sv | 138 +++++++++++++
 tb/tb_frame_stream_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_tx.sv
// Streams N frames of {pixel, depth} words from a frame buffer to the chip,
// pacing each frame after the first on the chip's feature-ready handshake.
module frame_stream_tx #(
    parameter int PIX_BW  = 8,
    parameter int DEP_BW  = 16,
    parameter int ADDR_BW = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_go,
    input  logic [3:0]               i_n_frames,
    input  logic [9:0]               i_hsize,
    input  logic [9:0]               i_vsize,
    input  logic                     i_abort,
    input  logic                     i_feature_ready,
    output logic                     o_mem_req,
    output logic [ADDR_BW-1:0]       o_mem_addr,
    input  logic [PIX_BW+DEP_BW-1:0] i_mem_rdata,
    output logic                     o_valid,
    output logic [PIX_BW-1:0]        o_pixel,
    output logic [DEP_BW-1:0]        o_depth,
    output logic                     o_frame_start,
    output logic [3:0]               o_frame_idx,
    output logic                     o_busy,
    output logic                     o_all_done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_RDY} state_t;

    state_t      state;
    logic [19:0] frame_size;
    logic [19:0] pix_cnt;
    logic [3:0]  n_frames;
    logic [3:0]  frame_idx;
    logic        ready_seen;

    logic [19:0] hv_size;
    logic        size_zero;
    logic        last_pix;
    logic        last_frame;

    assign hv_size    = {10'd0, i_hsize} * {10'd0, i_vsize};
    assign size_zero  = (i_hsize == 10'd0) || (i_vsize == 10'd0) || (i_n_frames == 4'd0);
    assign last_pix   = (pix_cnt == frame_size - 20'd1);
    assign last_frame = (frame_idx == n_frames - 4'd1);

    // Read data lands one cycle after the strobe, aligned with o_valid.
    assign o_pixel     = o_valid ? i_mem_rdata[PIX_BW+DEP_BW-1 -: PIX_BW] : '0;
    assign o_depth     = o_valid ? i_mem_rdata[DEP_BW-1:0] : '0;
    assign o_frame_idx = frame_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            frame_size    <= '0;
            pix_cnt       <= '0;
            n_frames      <= '0;
            frame_idx     <= '0;
            ready_seen    <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
            o_all_done    <= 1'b0;
        end else begin
            o_all_done    <= 1'b0;
            o_valid       <= o_mem_req;
            o_frame_start <= o_mem_req && (pix_cnt == '0);
            if (i_abort) begin
                state         <= IDLE;
                pix_cnt       <= '0;
                frame_idx     <= '0;
                ready_seen    <= 1'b0;
                o_mem_req     <= 1'b0;
                o_mem_addr    <= '0;
                o_valid       <= 1'b0;
                o_frame_start <= 1'b0;
                o_busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ready_seen <= 1'b0;
                        if (i_go) begin
                            if (size_zero) begin
                                o_all_done <= 1'b1;
                            end else begin
                                frame_size <= hv_size;
                                n_frames   <= i_n_frames;
                                frame_idx  <= '0;
                                pix_cnt    <= '0;
                                o_mem_addr <= '0;
                                o_mem_req  <= 1'b1;
                                o_busy     <= 1'b1;
                                state      <= STREAM;
                            end
                        end
                    end
                    STREAM: begin
                        ready_seen <= ready_seen | i_feature_ready;
                        // Frames are contiguous, so the running address already
                        // equals frame_idx*frame_size + pix_cnt.
                        o_mem_addr <= o_mem_addr + ADDR_BW'(1);
                        if (last_pix) begin
                            o_mem_req  <= 1'b0;
                            o_all_done <= last_frame;
                            state      <= DRAIN;
                        end else begin
                            pix_cnt <= pix_cnt + 20'd1;
                        end
                    end
                    DRAIN: begin
                        ready_seen <= ready_seen | i_feature_ready;
                        if (last_frame) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        if (ready_seen) begin
                            ready_seen <= 1'b0;
                            frame_idx  <= frame_idx + 4'd1;
                            pix_cnt    <= '0;
                            o_mem_req  <= 1'b1;
                            state      <= STREAM;
                        end else begin
                            ready_seen <= i_feature_ready;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx: job-level reference model compared every
// cycle, plus literal cycle-accurate expectations for the key scenarios.
module tb_frame_stream_tx;
    localparam int PW = 8;
    localparam int DW = 16;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_go = 1'b0;
    logic [3:0]    i_n_frames = '0;
    logic [9:0]    i_hsize = '0;
    logic [9:0]    i_vsize = '0;
    logic          i_abort = 1'b0;
    logic          i_feature_ready = 1'b0;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic [23:0]   mem_rdata = '0;
    logic          o_valid;
    logic [PW-1:0] o_pixel;
    logic [DW-1:0] o_depth;
    logic          o_frame_start;
    logic [3:0]    o_frame_idx;
    logic          o_busy;
    logic          o_all_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int g = 0;

    always #5 clk = ~clk;

    frame_stream_tx #(.PIX_BW(PW), .DEP_BW(DW), .ADDR_BW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_n_frames(i_n_frames),
        .i_hsize(i_hsize), .i_vsize(i_vsize), .i_abort(i_abort),
        .i_feature_ready(i_feature_ready), .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr), .i_mem_rdata(mem_rdata), .o_valid(o_valid),
        .o_pixel(o_pixel), .o_depth(o_depth), .o_frame_start(o_frame_start),
        .o_frame_idx(o_frame_idx), .o_busy(o_busy), .o_all_done(o_all_done)
    );

    function automatic logic [23:0] word(input int k);
        logic [15:0] d;
        d = 16'h100 + k[15:0];
        return {k[7:0], d};
    endfunction

    // Frame buffer: one-cycle read latency, junk when not strobed.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= o_mem_req ? word(int'(o_mem_addr)) : 24'hA5A5A5;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks the job as frame index + pixel index; addresses
    // are recomputed as idx*size+pix, pixels as the memory word at that address.
    int m_busy, m_req, m_idx, m_pix, m_fsz, m_nf, m_rdy, m_drain, m_wait;
    int m_valid, m_vaddr, m_fs, m_done;

    task automatic model_clear();
        m_busy = 0; m_req = 0; m_idx = 0; m_pix = 0; m_rdy = 0; m_drain = 0;
        m_wait = 0; m_valid = 0; m_vaddr = 0; m_fs = 0; m_done = 0;
    endtask

    task automatic model_step();
        int nv, nva, nfs, rdy_in, used;
        if (!rst_n) begin
            model_clear();
            m_fsz = 0; m_nf = 0;
            return;
        end
        nv = m_req; nva = m_idx * m_fsz + m_pix; nfs = (m_req != 0 && m_pix == 0) ? 1 : 0;
        m_done = 0;
        if (i_abort) begin
            model_clear();
            return;
        end
        rdy_in = (m_busy != 0 && i_feature_ready) ? 1 : 0;
        used = 0;
        if (m_busy == 0) begin
            m_rdy = 0;
            if (i_go) begin
                if (i_hsize == 0 || i_vsize == 0 || i_n_frames == 0) m_done = 1;
                else begin
                    m_fsz = int'(i_hsize) * int'(i_vsize); m_nf = int'(i_n_frames);
                    m_idx = 0; m_pix = 0; m_req = 1; m_busy = 1;
                end
            end
        end else if (m_req != 0) begin
            if (m_pix < m_fsz - 1) m_pix++;
            else begin
                m_req = 0; m_drain = 1; m_done = (m_idx == m_nf - 1) ? 1 : 0;
            end
        end else if (m_drain != 0) begin
            m_drain = 0;
            if (m_idx == m_nf - 1) m_busy = 0; else m_wait = 1;
        end else if (m_wait != 0 && m_rdy != 0) begin
            m_wait = 0; used = 1; m_idx++; m_pix = 0; m_req = 1;
        end
        if (used != 0) m_rdy = 0; else if (rdy_in != 0) m_rdy = 1;
        m_valid = nv; m_vaddr = nva; m_fs = nfs;
    endtask

    initial begin
        model_clear();
        m_fsz = 0; m_nf = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    always @(negedge clk) begin
        logic [23:0] w;
        w = word(m_vaddr);
        chk("busy", o_busy, m_busy);
        chk("mem_req", o_mem_req, m_req);
        if (m_req != 0) chk("mem_addr", o_mem_addr, (m_idx * m_fsz + m_pix) & ((1 << AW) - 1));
        chk("valid", o_valid, m_valid);
        chk("pixel", o_pixel, m_valid != 0 ? w[23:16] : 0);
        chk("depth", o_depth, m_valid != 0 ? w[15:0] : 0);
        chk("frame_start", o_frame_start, m_fs);
        chk("all_done", o_all_done, m_done);
        chk("frame_idx", o_frame_idx, m_idx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to(input int k);
        while (cyc < g + k) tick();
    endtask

    task automatic go_job(input int h, input int v, input int n);
        i_hsize = 10'(h); i_vsize = 10'(v); i_n_frames = 4'(n); i_go = 1'b1;
        g = cyc;
        tick();
        i_go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_busy", o_busy, 0);
        chk("rst_req", o_mem_req, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_idx", o_frame_idx, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(); tick();

        // single 4x2 frame
        go_job(4, 2, 1);
        @(negedge clk); chk("t33_req1", o_mem_req, 1); chk("t33_addr1", o_mem_addr, 0);
        chk("t33_val1", o_valid, 0);
        to(2); @(negedge clk); chk("t33_val2", o_valid, 1); chk("t33_pix2", o_pixel, 0);
        chk("t33_dep2", o_depth, 16'h100); chk("t33_fs2", o_frame_start, 1);
        to(8); @(negedge clk); chk("t33_addr8", o_mem_addr, 7); chk("t33_fs8", o_frame_start, 0);
        to(9); @(negedge clk); chk("t33_done9", o_all_done, 1); chk("t33_pix9", o_pixel, 7);
        chk("t33_dep9", o_depth, 16'h107); chk("t33_req9", o_mem_req, 0);
        to(10); @(negedge clk); chk("t33_busy10", o_busy, 0); chk("t33_done10", o_all_done, 0);
        to(12);

        // two frames, ready 5 cycles after drain
        go_job(4, 2, 2);
        to(12); @(negedge clk); chk("t34_wait_val", o_valid, 0); chk("t34_wait_busy", o_busy, 1);
        to(14); i_feature_ready = 1'b1; tick(); i_feature_ready = 1'b0;
        to(16); @(negedge clk); chk("t34_addr", o_mem_addr, 8); chk("t34_idx", o_frame_idx, 1);
        to(17); @(negedge clk); chk("t34_fs", o_frame_start, 1); chk("t34_pix", o_pixel, 8);
        to(24); @(negedge clk); chk("t34_done", o_all_done, 1); chk("t34_pix15", o_pixel, 15);
        to(27);

        // two frames, ready during frame 0
        go_job(4, 2, 2);
        to(3); i_feature_ready = 1'b1; tick(); i_feature_ready = 1'b0;
        to(10); @(negedge clk); chk("t35_wait_req", o_mem_req, 0); chk("t35_wait_busy", o_busy, 1);
        to(11); @(negedge clk); chk("t35_req", o_mem_req, 1); chk("t35_addr", o_mem_addr, 8);
        to(19); @(negedge clk); chk("t35_done", o_all_done, 1);
        to(21);

        // abort at pixel 3, then restart
        go_job(4, 2, 1);
        to(5); i_abort = 1'b1;
        @(negedge clk); chk("t36_pix3", o_pixel, 3);
        tick(); i_abort = 1'b0;
        @(negedge clk); chk("t36_val", o_valid, 0); chk("t36_busy", o_busy, 0);
        chk("t36_req", o_mem_req, 0);
        to(12);
        go_job(4, 2, 1);
        @(negedge clk); chk("t36_restart", o_mem_addr, 0); chk("t36_restart_req", o_mem_req, 1);
        to(11);

        // abort beats go in the same cycle
        i_abort = 1'b1; go_job(4, 2, 1); i_abort = 1'b0;
        @(negedge clk); chk("prio_busy", o_busy, 0); chk("prio_req", o_mem_req, 0);
        to(3);

        // zero size, then go while streaming
        go_job(4, 0, 1);
        @(negedge clk); chk("t37_done", o_all_done, 1); chk("t37_busy", o_busy, 0);
        chk("t37_req", o_mem_req, 0);
        to(3);
        go_job(4, 2, 1);
        to(3); i_hsize = 10'd2; i_vsize = 10'd1; i_n_frames = 4'd3; i_go = 1'b1;
        tick(); i_go = 1'b0;
        to(9); @(negedge clk); chk("t37_done9", o_all_done, 1); chk("t37_pix9", o_pixel, 7);
        to(11);

        // 1x1 frames with ready held high
        i_feature_ready = 1'b1;
        go_job(1, 1, 2);
        to(4); @(negedge clk); chk("min_addr", o_mem_addr, 1); chk("min_idx", o_frame_idx, 1);
        to(5); @(negedge clk); chk("min_done", o_all_done, 1);
        i_feature_ready = 1'b0;
        to(7);

        // asynchronous reset mid-frame
        go_job(4, 2, 1);
        to(4); rst_n = 1'b0; #1;
        chk("t38_val", o_valid, 0); chk("t38_req", o_mem_req, 0); chk("t38_addr", o_mem_addr, 0);
        chk("t38_busy", o_busy, 0); chk("t38_pix", o_pixel, 0); chk("t38_dep", o_depth, 0);
        tick(); rst_n = 1'b1;
        to(8); @(negedge clk); chk("t38_idle", o_busy, 0); chk("t38_idle_req", o_mem_req, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
